// File: rtl/mnist_pixel_frame_binarizer.sv
// Binarizes a serial 8-bit pixel stream into a double-buffered NUM_PIXELS-bit frame.
// Optional framing check (in_last / err_len) enabled by defining FRAME_LAST_CHECK_EN.
module mnist_pixel_frame_binarizer #(
  parameter int NUM_PIXELS = 784,
  parameter int PIXEL_W    = 8,
  parameter int THRESHOLD  = 128,
  parameter int CNT_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIXEL_W-1:0]    in_pixel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NUM_PIXELS-1:0] out_frame,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef FRAME_LAST_CHECK_EN
  input  logic                  in_last,
  output logic                  err_len,
`endif
  output logic [15:0]           frames_out
);

  typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_PIXELS-1:0] fill_q, fill_d;
  logic [NUM_PIXELS-1:0] out_frame_q, out_frame_d;
  logic                  out_valid_q, out_valid_d;
  logic [15:0]           frames_q, frames_d;
  logic                  err_q, err_d;

  logic accept_s;
  logic slot_free_s;
  logic pix_bit_s;
  logic is_last_s;

  assign in_ready    = (state_q == FILL);
  assign accept_s    = in_valid && in_ready;
  assign slot_free_s = !out_valid_q || out_ready;
  assign pix_bit_s   = (in_pixel >= PIXEL_W'(THRESHOLD));
  assign is_last_s   = (cnt_q == LAST_IDX);

  // Next-state, fill and output-slot logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    out_frame_d = out_frame_q;
    out_valid_d = out_valid_q && !out_ready;
    err_d       = 1'b0;
    case (state_q)
      FILL: begin
        if (accept_s) begin
          fill_d[cnt_q] = pix_bit_s;
          if (is_last_s) begin
            // Slot free: the completed frame (including this bit) goes straight out.
            if (slot_free_s) begin
              out_frame_d = fill_d;
              out_valid_d = 1'b1;
              cnt_d       = {CNT_W{1'b0}};
            end else begin
              state_d = HOLD;
            end
`ifdef FRAME_LAST_CHECK_EN
            err_d = !in_last;
`endif
          end else begin
`ifdef FRAME_LAST_CHECK_EN
            if (in_last) begin
              cnt_d = {CNT_W{1'b0}};
              err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
`else
            cnt_d = cnt_q + CNT_W'(1);
`endif
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      HOLD: begin
        if (slot_free_s) begin
          out_frame_d = fill_q;
          out_valid_d = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = FILL;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Consumed-frame counter, wraps naturally at 16 bits.
  always_comb begin
    frames_d = frames_q;
    if (out_valid_q && out_ready) begin
      frames_d = frames_q + 16'd1;
    end else begin
      frames_d = frames_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= {CNT_W{1'b0}};
      fill_q      <= {NUM_PIXELS{1'b0}};
      out_frame_q <= {NUM_PIXELS{1'b0}};
      out_valid_q <= 1'b0;
      frames_q    <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      out_frame_q <= out_frame_d;
      out_valid_q <= out_valid_d;
      frames_q    <= frames_d;
      err_q       <= err_d;
    end
  end

  assign out_frame  = out_frame_q;
  assign out_valid  = out_valid_q;
  assign frames_out = frames_q;
`ifdef FRAME_LAST_CHECK_EN
  assign err_len = err_q;
`else
  logic unused_err_s;
  assign unused_err_s = err_q;
`endif

endmodule

// File: tb/tb_mnist_pixel_frame_binarizer.sv
// Self-checking bench for mnist_pixel_frame_binarizer: frame scoreboard plus directed corner cases.
module tb_mnist_pixel_frame_binarizer;

  localparam int NP = 784;

  logic          clk;
  logic          rst_n;
  logic [7:0]    in_pixel;
  logic          in_valid;
  logic          in_ready;
  logic [NP-1:0] out_frame;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   frames_out;
`ifdef FRAME_LAST_CHECK_EN
  logic          in_last;
  logic          err_len;
  int            last_at_g;
`endif

  mnist_pixel_frame_binarizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_frame  (out_frame),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef FRAME_LAST_CHECK_EN
    .in_last    (in_last),
    .err_len    (err_len),
`endif
    .frames_out (frames_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pixel;
    logic       exp_bit;
  } vec_t;

  vec_t          tbl [8];
  logic [NP-1:0] exp_q [$];
  int            checks;
  int            errors;
  int            stall_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every consumed frame must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got %0h expected none", out_frame);
      end else begin
        chk_frame("frame_data", out_frame, exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] pix(input int kind, input int k);
    case (kind)
      0:       return 8'(k % 256);
      1:       return (k < 8) ? tbl[k].pixel : 8'd0;
      2:       return 8'd255;
      3:       return 8'd0;
      4:       return (k % 3 == 0) ? 8'd200 : 8'd10;
      default: return 8'((k * 7) % 256);
    endcase
  endfunction

  task automatic send_pixel(input logic [7:0] p);
    int n;
    n        = 0;
    in_pixel = p;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    stall_cnt += n;
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int kind, input int n);
    logic [NP-1:0] e;
    logic [7:0]    p;
    e = '0;
    for (int k = 0; k < n; k++) begin
      p    = pix(kind, k);
      e[k] = (p >= 8'd128);
`ifdef FRAME_LAST_CHECK_EN
      in_last = (k == last_at_g);
`endif
      send_pixel(p);
    end
    in_valid = 1'b0;
`ifdef FRAME_LAST_CHECK_EN
    in_last = 1'b0;
`endif
    if (n == NP) exp_q.push_back(e);
  endtask

  initial begin
    logic [NP-1:0] e4;
    logic [NP-1:0] e5;
    logic [NP-1:0] rest;
    checks    = 0;
    errors    = 0;
    stall_cnt = 0;
    in_pixel  = 8'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
`ifdef FRAME_LAST_CHECK_EN
    in_last   = 1'b0;
    last_at_g = NP - 1;
`endif
    tbl[0] = '{8'd127, 1'b0};
    tbl[1] = '{8'd128, 1'b1};
    tbl[2] = '{8'd255, 1'b1};
    tbl[3] = '{8'd0,   1'b0};
    tbl[4] = '{8'd129, 1'b1};
    tbl[5] = '{8'd1,   1'b0};
    tbl[6] = '{8'd200, 1'b1};
    tbl[7] = '{8'd126, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_frames_out", 64'(frames_out), 64'd0);
    chk("rst_out_frame_zero", 64'(out_frame == '0), 64'd1);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Ramp frame, consumer always ready.
    out_ready = 1'b1;
    send_frame(0, NP);
    chk("ramp_latency_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    chk("ramp_frames_out", 64'(frames_out), 64'd1);
    chk("ramp_valid_drop", 64'(out_valid), 64'd0);

    // Threshold table: frame held so its bits can be inspected.
    out_ready = 1'b0;
    send_frame(1, NP);
    chk("tbl_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tbl_bit%0d", i), 64'(out_frame[i]), 64'(tbl[i].exp_bit));
    end
    chk("tbl_low4", 64'(out_frame[3:0]), 64'h6);
    rest = out_frame >> 8;
    chk("tbl_upper_zero", 64'(rest == '0), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("tbl_frames_out", 64'(frames_out), 64'd2);

    // Back-to-back frames with no bubble.
    stall_cnt = 0;
    send_frame(2, NP);
    send_frame(3, NP);
    chk("b2b_no_stall", 64'(stall_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_frames_out", 64'(frames_out), 64'd4);

    // Slot busy: second frame parks in HOLD until the consumer returns.
    out_ready = 1'b0;
    send_frame(4, NP);
    send_frame(5, NP);
    e4 = exp_q[0];
    e5 = exp_q[1];
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk_frame("hold_stable_frame", out_frame, e4);
    chk("hold_still_blocked", 64'(in_ready), 64'd0);
    chk("hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_xfer_valid", 64'(out_valid), 64'd1);
    chk_frame("hold_xfer_frame", out_frame, e5);
    chk("hold_in_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("hold_frames_out", 64'(frames_out), 64'd6);
    chk("hold_valid_drop", 64'(out_valid), 64'd0);

    // Reset mid-frame discards the partial frame.
    send_frame(0, 400);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_frames", 64'(frames_out), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(5, NP);
    @(posedge clk);
    #1;
    chk("midrst_frames_out", 64'(frames_out), 64'd1);
    chk("midrst_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef FRAME_LAST_CHECK_EN
    // Early in_last aborts the frame with an error pulse.
    last_at_g = 99;
    send_frame(0, 100);
    chk("len_err_pulse", 64'(err_len), 64'd1);
    chk("len_no_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("len_err_single", 64'(err_len), 64'd0);
    last_at_g = NP - 1;
    send_frame(4, NP);
    chk("len_good_err", 64'(err_len), 64'd0);
    @(posedge clk);
    #1;
    chk("len_frames_out", 64'(frames_out), 64'd2);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
